// File: rtl/gp_isa_pkg.sv
// Shared ISA definitions for the general-purpose register machine:
// opcode and FSM state encodings plus instruction-width helpers.
package gp_isa_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_LNOT = 2'b11
    } gp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_EXEC = 2'b10,
        ST_DONE = 2'b11
    } gp_state_e;

    function automatic int gp_dw(input int nreg);
        return $clog2(nreg);
    endfunction

    function automatic int gp_sw(input int nreg, input int nin);
        return $clog2((nreg > nin) ? nreg : nin);
    endfunction

    // Instruction word: op[1:0], dst[DW], src_is_in, src[SW]
    function automatic int gp_iw(input int nreg, input int nin);
        return 2 + gp_dw(nreg) + 1 + gp_sw(nreg, nin);
    endfunction

endpackage

// File: rtl/gp_regmachine_if.sv
// Bus bundle for gp_regmachine: program port, input/result handshakes and status.
interface gp_regmachine_if
    import gp_isa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREG  = 4,
    parameter int NIN   = 4,
    parameter int DEPTH = 64
);
    localparam int IW = gp_iw(NREG, NIN);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic                  prog_we;
    logic [AW-1:0]         prog_addr;
    logic [IW-1:0]         prog_data;
    logic [LW-1:0]         prog_len;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; the source holds data stable while valid is high and ready low.
    logic                  in_valid;
    logic                  in_ready;
    logic [NIN*WIDTH-1:0]  in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [NREG*WIDTH-1:0] out_data;

    logic                  busy;
    logic                  prog_lock_err;

    modport master (
        output prog_we, prog_addr, prog_data, prog_len,
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, prog_lock_err
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, prog_len,
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, prog_lock_err
    );

endinterface

// File: rtl/gp_prog_mem.sv
// Program store: DEPTH x IW array, synchronous write, combinational read, no reset.
module gp_prog_mem #(
    parameter int DEPTH = 64,
    parameter int IW    = 7
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [IW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [IW-1:0]            rdata
);
    logic [IW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/gp_regmachine.sv
// Tiny logic-op register machine: loads input words into registers, runs a stored
// program one instruction per cycle, then presents the register file.
module gp_regmachine
    import gp_isa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREG  = 4,
    parameter int NIN   = 4,
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    gp_regmachine_if.slave bus,
    output gp_state_e  dbg_state
);
    localparam int DW = gp_dw(NREG);
    localparam int SW = gp_sw(NREG, NIN);
    localparam int IW = gp_iw(NREG, NIN);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    gp_state_e             state;
    logic [LW-1:0]         pc;
    logic [LW-1:0]         len;
    logic [LW-1:0]         len_in;
    logic [NIN*WIDTH-1:0]  in_q;
    logic [NREG*WIDTH-1:0] load_vec;
    logic [NREG*WIDTH-1:0] out_vec;
    logic [WIDTH-1:0]      regs [NREG];
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  busy_q;
    logic                  lock_err_q;

    logic [IW-1:0]         instr;
    gp_op_e                op;
    logic [DW-1:0]         dst_f;
    logic                  src_in;
    logic [SW-1:0]         src_f;
    int                    dst_i;
    int                    src_i;
    logic [WIDTH-1:0]      operand;
    logic [WIDTH-1:0]      dst_val;
    logic [WIDTH-1:0]      result;

    // Writes are only honoured in IDLE so a running program never changes under itself.
    gp_prog_mem #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_prog_mem (
        .clk   (clk),
        .we    (bus.prog_we && (state == ST_IDLE)),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .raddr (pc[AW-1:0]),
        .rdata (instr)
    );

    assign len_in   = (bus.prog_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.prog_len;
    assign load_vec = (NREG*WIDTH)'(in_q);

    always_comb begin
        op      = gp_op_e'(instr[IW-1 -: 2]);
        dst_f   = instr[IW-3 -: DW];
        src_in  = instr[SW];
        src_f   = instr[SW-1:0];
        dst_i   = int'(dst_f) % NREG;
        src_i   = src_in ? (int'(src_f) % NIN) : (int'(src_f) % NREG);
        operand = '0;
        dst_val = '0;
        if (src_in) begin
            for (int i = 0; i < NIN; i++) begin
                if (i == src_i) operand = in_q[i*WIDTH +: WIDTH];
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (i == src_i) operand = regs[i];
            end
        end
        for (int i = 0; i < NREG; i++) begin
            if (i == dst_i) dst_val = regs[i];
        end
        case (op)
            OP_AND:  result = dst_val & operand;
            OP_OR:   result = dst_val | operand;
            OP_XOR:  result = dst_val ^ operand;
            default: result = (operand == '0) ? WIDTH'(1) : '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= '0;
            len         <= '0;
            in_q        <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            lock_err_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (bus.prog_we && (state != ST_IDLE)) lock_err_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        in_q       <= bus.in_data;
                        len        <= len_in;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    for (int i = 0; i < NREG; i++) regs[i] <= load_vec[i*WIDTH +: WIDTH];
                    pc <= '0;
                    if (len == '0) begin
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    for (int i = 0; i < NREG; i++) begin
                        if (i == dst_i) regs[i] <= result;
                    end
                    pc <= pc + 1'b1;
                    if (pc == len - 1'b1) begin
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                default: begin
                    // Registers are untouched here, so out_data holds while stalled.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        out_vec = '0;
        for (int i = 0; i < NREG; i++) out_vec[i*WIDTH +: WIDTH] = regs[i];
    end

    assign bus.out_data      = out_vec;
    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.busy          = busy_q;
    assign bus.prog_lock_err = lock_err_q;
    assign dbg_state         = state;

endmodule

// File: doc/gp_regmachine.md
GP_REGMACHINE -- requirements
Module: gp_regmachine

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bit width of each register, input word and output word.
REQ-002 SHALL have parameter NREG, default 4, number of working registers (≥2).
REQ-003 SHALL have parameter NIN, default 4, number of input words (1..NREG).
REQ-004 SHALL have parameter DEPTH, default 64, program memory depth in instructions.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 prog_we  input  1  program-memory write strobe.
REQ-008 prog_addr  input  clog2(DEPTH)  program write address.
REQ-009 prog_data  input  IW  instruction word; IW = 2 + DW + 1 + SW, where DW = clog2(NREG) and SW = clog2(max(NREG,NIN)).
REQ-010 prog_len  input  clog2(DEPTH+1)  number of instructions to execute; sampled at input accept.
REQ-011 in_valid / in_ready  input / output  1 each  input handshake.
REQ-012 in_data  input  NIN*WIDTH  input words; word i occupies bits [i*WIDTH +: WIDTH].
REQ-013 out_valid / out_ready  output / input  1 each  result handshake.
REQ-014 out_data  output  NREG*WIDTH  final register file; word i is register ri.
REQ-015 busy  output  1  high in LOAD, EXEC and DONE.
REQ-016 prog_lock_err  output  1  sticky; set when a program write is attempted while busy.

Function
REQ-017 Instruction fields, MSB to LSB: op[1:0], dst[DW], src_is_in[1], src[SW].
REQ-018 Ops: 00 AND (rd = rd & s), 01 OR (rd = rd | s), 10 XOR (rd = rd ^ s), 11 LNOT (rd = (s == 0) ? 1 : 0, zero-extended to WIDTH).
REQ-019 Operand s is register r[src] when src_is_in = 0, otherwise in word in[src] captured at accept.
REQ-020 Out-of-range src or dst indices SHALL wrap modulo NREG (registers) or modulo NIN (input words).
REQ-021 FSM states are IDLE, LOAD, EXEC and DONE.
REQ-022 IDLE: in_ready = 1; on in_valid & in_ready, capture in_data, capture min(prog_len, DEPTH) as len, and go to LOAD.
REQ-023 LOAD: set ri = in[i] for i < NIN and ri = 0 otherwise; set pc = 0; go to EXEC if len > 0, else DONE.
REQ-024 EXEC: execute exactly one instruction per cycle, in order pc = 0..len-1; after pc = len-1 executes, go to DONE.
REQ-025 DONE: out_valid = 1 and out_data holds the register file; on out_ready, go to IDLE.
REQ-026 out_data SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-027 Latency: from the accept edge, out_valid SHALL rise after len + 2 cycles.
REQ-028 prog_we in IDLE SHALL write mem[prog_addr]; prog_we in any other state SHALL be ignored and SHALL set prog_lock_err.
REQ-029 A write and an accept in the same IDLE cycle: the write SHALL complete first and be visible to that run.
REQ-030 in_ready SHALL be 0 in every state except IDLE; there is no overlap between runs.

Reset
REQ-031 While rst_n = 0: state = IDLE, pc = 0, all registers = 0, out_valid = 0, in_ready = 0, busy = 0, prog_lock_err = 0, out_data = 0.
REQ-032 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-033 Reset during EXEC or DONE SHALL abort the run with no output.
REQ-034 Program memory contents are not reset.

Structure
REQ-035 Package gp_isa_pkg SHALL hold the op enum (OP_AND, OP_OR, OP_XOR, OP_LNOT), the FSM state enum, and a function computing IW from the parameters.
REQ-036 The program store SHALL be one sub-module, gp_prog_mem: synchronous write, combinational read, DEPTH x IW.

Verification
REQ-037 Reset: assert rst_n low mid-EXEC -> all outputs 0 immediately; in_ready = 1 one cycle after release.
REQ-038 Program [XOR r0,r0], len 1, in = {0x1234, 0xABCD, 0x00FF, 0x8000} -> out = {0x0000, 0xABCD, 0x00FF, 0x8000}; out_valid 3 cycles after accept.
REQ-039 Program [LNOT r1,in0]: in0 = 0x0000 -> r1 = 0x0001; in0 = 0x8000 -> r1 = 0x0000.
REQ-040 prog_len = 0 -> out_data equals in_data; out_valid 2 cycles after accept; prog_len = 100 -> exactly 64 instructions execute.
REQ-041 Hold out_ready low for 5 cycles in DONE -> out_data stable, in_ready = 0; release -> IDLE, and the next accept succeeds.
REQ-042 Assert prog_we during EXEC -> memory unchanged (re-run gives identical result) and prog_lock_err = 1 until reset.
